// File: rtl/apb2axi_cpl_arbiter.sv
// Completion arbiter: merges read and write completions into the
// single completion FIFO push port through per-source elastic buffers.
module apb2axi_cpl_arbiter #(
    parameter int CPL_W     = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic                             rd_cpl_vld,
    input  logic [CPL_W-1:0]                 rd_cpl_data,
    output logic                             rd_cpl_rdy,
    input  logic                             wr_cpl_vld,
    input  logic [CPL_W-1:0]                 wr_cpl_data,
    output logic                             wr_cpl_rdy,
    output logic                             cq_push_vld,
    output logic [CPL_W-1:0]                 cq_push_data,
    input  logic                             cq_push_rdy,
    output logic [$clog2(BUF_DEPTH+1)-1:0]   rd_occ,
    output logic [$clog2(BUF_DEPTH+1)-1:0]   wr_occ,
    output logic                             last_grant,
    output logic [15:0]                      cpl_cnt
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BUF_DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [CPL_W-1:0] rd_mem [BUF_DEPTH];
    logic [CPL_W-1:0] wr_mem [BUF_DEPTH];
    logic [PTR_W-1:0] rd_wptr;
    logic [PTR_W-1:0] rd_rptr;
    logic [PTR_W-1:0] wr_wptr;
    logic [PTR_W-1:0] wr_rptr;

    logic             rd_push;
    logic             wr_push;
    logic             rd_pop;
    logic             wr_pop;
    logic             rd_ne;
    logic             wr_ne;
    logic             out_free;
    logic             gnt_rd;
    logic             gnt_wr;
    logic [CPL_W-1:0] pop_data;

    // Ready depends only on registered occupancy; held low during reset
    always_comb begin
        rd_cpl_rdy = !areset && (rd_occ < OCC_FULL);
        wr_cpl_rdy = !areset && (wr_occ < OCC_FULL);
        rd_push    = rd_cpl_vld && rd_cpl_rdy;
        wr_push    = wr_cpl_vld && wr_cpl_rdy;
        rd_ne      = (rd_occ != '0);
        wr_ne      = (wr_occ != '0);
        out_free   = !cq_push_vld || cq_push_rdy;
    end

    // Round-robin grant: a tie goes to the source not granted last
    always_comb begin
        gnt_rd = 1'b0;
        gnt_wr = 1'b0;
        if (out_free) begin
            unique case (1'b1)
                (rd_ne && !wr_ne): gnt_rd = 1'b1;
                (!rd_ne && wr_ne): gnt_wr = 1'b1;
                (rd_ne && wr_ne): begin
                    gnt_rd = last_grant;
                    gnt_wr = !last_grant;
                end
                default: ;
            endcase
        end
    end

    // Pop strobes and head-of-buffer selection for the output stage
    always_comb begin
        rd_pop   = gnt_rd;
        wr_pop   = gnt_wr;
        pop_data = gnt_wr ? wr_mem[wr_rptr] : rd_mem[rd_rptr];
    end

    // Buffer storage; contents need no reset
    always_ff @(posedge aclk) begin
        if (rd_push) rd_mem[rd_wptr] <= rd_cpl_data;
        if (wr_push) wr_mem[wr_wptr] <= wr_cpl_data;
    end

    // Read buffer pointers and occupancy
    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_wptr <= '0;
            rd_rptr <= '0;
            rd_occ  <= '0;
        end else begin
            if (rd_push) rd_wptr <= rd_wptr + PTR_ONE;
            if (rd_pop)  rd_rptr <= rd_rptr + PTR_ONE;
            case ({rd_push, rd_pop})
                2'b10:   rd_occ <= rd_occ + OCC_ONE;
                2'b01:   rd_occ <= rd_occ - OCC_ONE;
                default: rd_occ <= rd_occ;
            endcase
        end
    end

    // Write buffer pointers and occupancy
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_wptr <= '0;
            wr_rptr <= '0;
            wr_occ  <= '0;
        end else begin
            if (wr_push) wr_wptr <= wr_wptr + PTR_ONE;
            if (wr_pop)  wr_rptr <= wr_rptr + PTR_ONE;
            case ({wr_push, wr_pop})
                2'b10:   wr_occ <= wr_occ + OCC_ONE;
                2'b01:   wr_occ <= wr_occ - OCC_ONE;
                default: wr_occ <= wr_occ;
            endcase
        end
    end

    // Output register: load on grant, clear once consumed with nothing new
    always_ff @(posedge aclk) begin
        if (areset) begin
            cq_push_vld  <= 1'b0;
            cq_push_data <= '0;
            last_grant   <= 1'b1;
        end else if (gnt_rd || gnt_wr) begin
            cq_push_vld  <= 1'b1;
            cq_push_data <= pop_data;
            last_grant   <= gnt_wr;
        end else if (cq_push_rdy) begin
            cq_push_vld  <= 1'b0;
        end
    end

    // Saturating count of delivered completions
    always_ff @(posedge aclk) begin
        if (areset) begin
            cpl_cnt <= '0;
        end else if (cq_push_vld && cq_push_rdy && (cpl_cnt != 16'hFFFF)) begin
            cpl_cnt <= cpl_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_apb2axi_cpl_arbiter.sv
// Directed bench for apb2axi_cpl_arbiter: per-cycle vector table plus
// saturation and mid-operation reset sequences.
module tb_apb2axi_cpl_arbiter;

    logic        aclk = 1'b0;
    logic        areset;
    logic        rd_cpl_vld;
    logic [31:0] rd_cpl_data;
    logic        rd_cpl_rdy;
    logic        wr_cpl_vld;
    logic [31:0] wr_cpl_data;
    logic        wr_cpl_rdy;
    logic        cq_push_vld;
    logic [31:0] cq_push_data;
    logic        cq_push_rdy;
    logic [1:0]  rd_occ;
    logic [1:0]  wr_occ;
    logic        last_grant;
    logic [15:0] cpl_cnt;

    int checks   = 0;
    int failures = 0;

    apb2axi_cpl_arbiter #(.CPL_W(32), .BUF_DEPTH(2)) dut (
        .aclk         (aclk),
        .areset       (areset),
        .rd_cpl_vld   (rd_cpl_vld),
        .rd_cpl_data  (rd_cpl_data),
        .rd_cpl_rdy   (rd_cpl_rdy),
        .wr_cpl_vld   (wr_cpl_vld),
        .wr_cpl_data  (wr_cpl_data),
        .wr_cpl_rdy   (wr_cpl_rdy),
        .cq_push_vld  (cq_push_vld),
        .cq_push_data (cq_push_data),
        .cq_push_rdy  (cq_push_rdy),
        .rd_occ       (rd_occ),
        .wr_occ       (wr_occ),
        .last_grant   (last_grant),
        .cpl_cnt      (cpl_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int rv;
        int rd;
        int wv;
        int wd;
        int pr;
        int ev;
        int ed;
        int ero;
        int ewo;
        int elg;
        int ecnt;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(int rv, int rd, int wv, int wd, int pr,
                                int ev, int ed, int ero, int ewo,
                                int elg, int ecnt);
        vec_t v;
        v.rv = rv; v.rd = rd; v.wv = wv; v.wd = wd; v.pr = pr;
        v.ev = ev; v.ed = ed; v.ero = ero; v.ewo = ewo;
        v.elg = elg; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        // Collision after reset: read wins the first tie
        vt.push_back(mk(1, 'hA1, 1, 'hB1, 1, 0, 'h00, 1, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 'hA1, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 'hB1, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 'hB1, 0, 0, 1, 2));
        // Fairness: both sources streaming
        vt.push_back(mk(1, 'h1, 1, 'h9, 1, 0, 'hB1, 1, 1, 1, 2));
        vt.push_back(mk(1, 'h2, 1, 'hA, 1, 1, 'h1, 1, 2, 0, 2));
        vt.push_back(mk(1, 'h3, 1, 'hB, 1, 1, 'h9, 2, 1, 1, 3));
        vt.push_back(mk(0, 0, 1, 'hB, 1, 1, 'h2, 1, 2, 0, 4));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 'hA, 1, 1, 1, 5));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 'h3, 0, 1, 0, 6));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 'hB, 0, 0, 1, 7));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 'hB, 0, 0, 1, 8));
        // Single read: visible two edges after acceptance
        vt.push_back(mk(1, 'h11, 0, 0, 1, 0, 'hB, 1, 0, 1, 8));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 'h11, 0, 0, 0, 8));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 'h11, 0, 0, 0, 9));
        // Backpressure: six stalled cycles, 0x24 waits for space
        vt.push_back(mk(1, 'h21, 0, 0, 0, 0, 'h11, 1, 0, 0, 9));
        vt.push_back(mk(1, 'h22, 0, 0, 0, 1, 'h21, 1, 0, 0, 9));
        vt.push_back(mk(1, 'h23, 0, 0, 0, 1, 'h21, 2, 0, 0, 9));
        vt.push_back(mk(1, 'h24, 0, 0, 0, 1, 'h21, 2, 0, 0, 9));
        vt.push_back(mk(1, 'h24, 0, 0, 0, 1, 'h21, 2, 0, 0, 9));
        vt.push_back(mk(1, 'h24, 0, 0, 0, 1, 'h21, 2, 0, 0, 9));
        vt.push_back(mk(1, 'h24, 0, 0, 1, 1, 'h22, 1, 0, 0, 10));
        vt.push_back(mk(1, 'h24, 0, 0, 1, 1, 'h23, 1, 0, 0, 11));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 'h24, 0, 0, 0, 12));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 'h24, 0, 0, 0, 13));

        areset      = 1'b1;
        rd_cpl_vld  = 1'b1;
        rd_cpl_data = 32'hDEAD;
        wr_cpl_vld  = 1'b1;
        wr_cpl_data = 32'hBEEF;
        cq_push_rdy = 1'b1;
        step();
        step();
        chk("rst_rd_rdy", 32'(rd_cpl_rdy), 0);
        chk("rst_wr_rdy", 32'(wr_cpl_rdy), 0);
        rd_cpl_vld = 1'b0;
        wr_cpl_vld = 1'b0;
        areset     = 1'b0;
        #1;
        chk("rst_vld", 32'(cq_push_vld), 0);
        chk("rst_data", cq_push_data, 0);
        chk("rst_rd_occ", 32'(rd_occ), 0);
        chk("rst_wr_occ", 32'(wr_occ), 0);
        chk("rst_lg", 32'(last_grant), 1);
        chk("rst_cnt", 32'(cpl_cnt), 0);
        chk("rst_rd_rdy_rel", 32'(rd_cpl_rdy), 1);

        for (int i = 0; i < vt.size(); i++) begin
            rd_cpl_vld  = (vt[i].rv != 0);
            rd_cpl_data = vt[i].rd;
            wr_cpl_vld  = (vt[i].wv != 0);
            wr_cpl_data = vt[i].wd;
            cq_push_rdy = (vt[i].pr != 0);
            step();
            chk($sformatf("row%0d vld", i), 32'(cq_push_vld), vt[i].ev);
            chk($sformatf("row%0d data", i), cq_push_data, vt[i].ed);
            chk($sformatf("row%0d rd_occ", i), 32'(rd_occ), vt[i].ero);
            chk($sformatf("row%0d wr_occ", i), 32'(wr_occ), vt[i].ewo);
            chk($sformatf("row%0d lg", i), 32'(last_grant), vt[i].elg);
            chk($sformatf("row%0d cnt", i), 32'(cpl_cnt), vt[i].ecnt);
            chk($sformatf("row%0d rd_rdy", i), 32'(rd_cpl_rdy),
                (vt[i].ero < 2) ? 1 : 0);
            chk($sformatf("row%0d wr_rdy", i), 32'(wr_cpl_rdy),
                (vt[i].ewo < 2) ? 1 : 0);
        end

        // Saturation: one handshake per edge from edge 3 on, cnt starts at 13
        rd_cpl_vld  = 1'b1;
        rd_cpl_data = 32'h55;
        wr_cpl_vld  = 1'b0;
        cq_push_rdy = 1'b1;
        for (int e = 1; e <= 65530; e++) begin
            step();
            if (e == 65523) chk("sat_fffe", 32'(cpl_cnt), 32'hFFFE);
            if (e == 65524) chk("sat_ffff", 32'(cpl_cnt), 32'hFFFF);
        end
        chk("sat_hold", 32'(cpl_cnt), 32'hFFFF);
        chk("sat_vld", 32'(cq_push_vld), 1);
        chk("sat_occ", 32'(rd_occ), 1);
        step();
        chk("sat_extra", 32'(cpl_cnt), 32'hFFFF);
        rd_cpl_vld = 1'b0;
        step();
        step();
        step();
        chk("drain_vld", 32'(cq_push_vld), 0);
        chk("drain_occ", 32'(rd_occ), 0);
        chk("drain_cnt", 32'(cpl_cnt), 32'hFFFF);

        // Reset mid-operation with a full read buffer and staged output
        cq_push_rdy = 1'b0;
        rd_cpl_vld  = 1'b1;
        rd_cpl_data = 32'h31;
        step();
        rd_cpl_data = 32'h32;
        step();
        rd_cpl_data = 32'h33;
        step();
        rd_cpl_vld = 1'b0;
        chk("mid_occ", 32'(rd_occ), 2);
        chk("mid_vld", 32'(cq_push_vld), 1);
        chk("mid_data", cq_push_data, 32'h31);
        areset      = 1'b1;
        rd_cpl_vld  = 1'b1;
        rd_cpl_data = 32'h34;
        #1;
        chk("mid_rst_rdy", 32'(rd_cpl_rdy), 0);
        step();
        areset      = 1'b0;
        rd_cpl_vld  = 1'b0;
        cq_push_rdy = 1'b1;
        chk("mrst_vld", 32'(cq_push_vld), 0);
        chk("mrst_occ", 32'(rd_occ), 0);
        chk("mrst_lg", 32'(last_grant), 1);
        chk("mrst_cnt", 32'(cpl_cnt), 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("post%0d vld", k), 32'(cq_push_vld), 0);
            chk($sformatf("post%0d occ", k), 32'(rd_occ), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
